psum_acc_ctrl: RTL and testbench
================================

PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 Parameter col, default 8: MAC array columns, i.e. the number of psum lanes per word.
REQ-002 Parameter psum_bw, default 16: signed psum lane width.
REQ-003 Parameter n_out, default 36: psum words per kij pass.
REQ-004 Parameter n_kij, default 9: kij passes per sequence.
REQ-005 Parameter addr_w, default 9: PMEM address width.
REQ-006 The block SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 reset  in  1  synchronous, active-low reset.
REQ-009 start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
REQ-010 base_addr  in  addr_w  PMEM region base address; latched on an accepted start.
REQ-011 relu_en  in  1  apply ReLU on the final pass; latched on an accepted start.
REQ-012 ofifo_valid  in  1  OFIFO head word available.
REQ-013 ofifo_out  in  psum_bw*col  OFIFO head word; first-word-fall-through.
REQ-014 ofifo_rd  out  1  OFIFO pop strobe.
REQ-015 pmem_q  in  psum_bw*col  PMEM read data; valid one cycle after the read cycle.
REQ-016 pmem_d  out  psum_bw*col  PMEM write data.
REQ-017 pmem_addr  out  addr_w  PMEM address.
REQ-018 pmem_cen  out  1  PMEM chip enable, active-low.
REQ-019 pmem_wen  out  1  PMEM write enable, active-low.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse on sequence completion.
REQ-022 sat_flag  out  1  sticky flag: some lane saturated during the current sequence.

Function
REQ-023 FSM states SHALL be IDLE, WAIT, RD, ACC, WR, DONE; all outputs are decoded from registered state and registered datapath values.
REQ-024 IDLE -> WAIT on start=1. On that edge: kij=0, idx=0, sat_flag=0; base_addr and relu_en are latched.
REQ-025 start while not in IDLE SHALL be ignored, with no side effects.
REQ-026 WAIT: ofifo_rd = ofifo_valid (combinational). When ofifo_valid=1, ofifo_out is captured into the data register on that edge.
REQ-027 WAIT transition on ofifo_valid=1: to WR if kij==0, else to RD. With ofifo_valid=0 the FSM stays in WAIT indefinitely, with no PMEM access.
REQ-028 ofifo_rd SHALL be 0 in every state other than WAIT, and high for exactly one cycle per consumed word.
REQ-029 RD: pmem_cen=0, pmem_wen=1, pmem_addr=base+idx; next state ACC.
REQ-030 ACC: per lane, signed sum = pmem_q lane + captured lane, saturated to [-2^(psum_bw-1), 2^(psum_bw-1)-1]; result registered; next state WR.
REQ-031 Any saturated lane SHALL set sat_flag, which stays set until the next accepted start or reset.
REQ-032 WR: pmem_cen=0, pmem_wen=0, pmem_addr=base+idx.
REQ-033 WR data for kij==0 SHALL be the captured word unmodified; for kij>0 it SHALL be the registered sum.
REQ-034 When kij==n_kij-1 and the latched relu_en=1, negative lanes SHALL be written as 0 (ReLU applied after saturation).
REQ-035 Leaving WR with idx<n_out-1: idx+1, next WAIT.
REQ-036 Leaving WR with idx==n_out-1 and kij<n_kij-1: idx=0, kij+1, next WAIT.
REQ-037 Leaving WR with idx==n_out-1 and kij==n_kij-1: next DONE.
REQ-038 DONE: done=1 for exactly one cycle; next IDLE.
REQ-039 Address arithmetic SHALL be modulo 2^addr_w; a wrap past the top of PMEM is not flagged.
REQ-040 Outside RD/WR: pmem_cen=1, pmem_wen=1; pmem_addr and pmem_d hold their last values.
REQ-041 Cycle cost per word: 2 cycles (WAIT, WR) on pass 0 and 4 cycles (WAIT, RD, ACC, WR) on later passes, with ofifo_valid held high.

Reset
REQ-042 With reset=0 at a rising edge, the next state SHALL be IDLE with kij=0, idx=0, sat_flag=0, busy=0, done=0, ofifo_rd=0, pmem_cen=1, pmem_wen=1, pmem_addr=0, pmem_d=0.
REQ-043 Reset asserted mid-sequence SHALL abort without any further PMEM write. PMEM contents are undefined; the OFIFO is not drained.
REQ-044 The first start is accepted on the first edge with reset=1 and start=1.

Verification
REQ-045 Single word: n_kij=1, n_out=1, base=5, ofifo word with all lanes 3 -> one write to addr 5 with all lanes 3; done 2 cycles after the WAIT pop; pmem_q is never read.
REQ-046 Accumulation: n_kij=9, n_out=36, OFIFO lanes = kij+1 -> every address base..base+35 finally holds 45 in all lanes; done pulses once; exactly 324 pops.
REQ-047 Saturation: PMEM preloaded with lane 0x7FF0, OFIFO lane 0x0020 -> lane written 0x7FFF and sat_flag=1. A negative lane written 0x8000 also sets sat_flag.
REQ-048 ReLU: relu_en=1, final-pass sum -7 -> lane written 0. With relu_en=0 the same case writes 0xFFF9.
REQ-049 Stall and ignore: ofifo_valid low for 10 cycles inside a pass -> FSM holds WAIT with cen=1; start pulsed while busy -> no effect on kij or idx.
REQ-050 Reset during a pass-3 RD -> next cycle IDLE with cen=1 and wen=1; a fresh start re-runs correctly from kij=0.

Source files
------------

// File: rtl/psum_acc_ctrl.sv
`timescale 1ns/1ps
// Partial-sum accumulation controller: pops OFIFO words and accumulates them
// into PMEM across n_kij passes, with lane saturation and optional final ReLU.
module psum_acc_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int n_out   = 36,
    parameter int n_kij   = 9,
    parameter int addr_w  = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w-1:0]        base_addr,
    input  logic                     relu_en,
    input  logic                     ofifo_valid,
    input  logic [psum_bw*col-1:0]   ofifo_out,
    output logic                     ofifo_rd,
    input  logic [psum_bw*col-1:0]   pmem_q,
    output logic [psum_bw*col-1:0]   pmem_d,
    output logic [addr_w-1:0]        pmem_addr,
    output logic                     pmem_cen,
    output logic                     pmem_wen,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);

    localparam int word_w = psum_bw * col;
    localparam int idx_w  = (n_out > 1) ? $clog2(n_out) : 1;
    localparam int kij_w  = (n_kij > 1) ? $clog2(n_kij) : 1;
    localparam logic [idx_w-1:0] idx_last = idx_w'(n_out - 1);
    localparam logic [kij_w-1:0] kij_last = kij_w'(n_kij - 1);
    localparam logic signed [psum_bw:0] lane_max = {2'b00, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw:0] lane_min = {2'b11, {(psum_bw-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, WAIT, RD, ACC, WR, DONE} state_t;

    state_t              state_q, state_d;
    logic [kij_w-1:0]    kij_q, kij_d;
    logic [idx_w-1:0]    idx_q, idx_d;
    logic [addr_w-1:0]   base_q, base_d;
    logic                relu_q, relu_d;
    logic [word_w-1:0]   data_q, data_d;
    logic                sat_q, sat_d;
    logic [addr_w-1:0]   pmem_addr_q, pmem_addr_d;
    logic [word_w-1:0]   pmem_d_q, pmem_d_d;
    logic                cen_q, cen_d;
    logic                wen_q, wen_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [word_w-1:0]   acc_word;
    logic                acc_sat;
    logic [psum_bw-1:0]  lane_a, lane_b, lane_res;
    logic signed [psum_bw:0] lane_sum;
    logic [addr_w-1:0]   cur_addr;
    logic                relu_apply;

    function automatic logic [word_w-1:0] relu_word(input logic [word_w-1:0] w);
        logic [word_w-1:0] r;
        r = w;
        for (int l = 0; l < col; l++) begin
            if (w[l*psum_bw + psum_bw - 1]) r[l*psum_bw +: psum_bw] = '0;
        end
        return r;
    endfunction

    assign cur_addr   = base_q + addr_w'(idx_q);
    assign relu_apply = relu_q && (kij_q == kij_last);

    // Lane-wise signed add with one guard bit, clamped to the psum range.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        acc_word = '0;
        acc_sat  = 1'b0;
        lane_a   = '0;
        lane_b   = '0;
        lane_sum = '0;
        lane_res = '0;
        for (int l = 0; l < col; l++) begin
            lane_a   = pmem_q[l*psum_bw +: psum_bw];
            lane_b   = data_q[l*psum_bw +: psum_bw];
            lane_sum = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
            if (lane_sum > lane_max) begin
                lane_res = lane_max[psum_bw-1:0];
                acc_sat  = 1'b1;
            end else if (lane_sum < lane_min) begin
                lane_res = lane_min[psum_bw-1:0];
                acc_sat  = 1'b1;
            end else begin
                lane_res = lane_sum[psum_bw-1:0];
            end
            acc_word[l*psum_bw +: psum_bw] = lane_res;
        end
    end

    always_comb begin
        state_d     = state_q;
        kij_d       = kij_q;
        idx_d       = idx_q;
        base_d      = base_q;
        relu_d      = relu_q;
        data_d      = data_q;
        sat_d       = sat_q;
        pmem_addr_d = pmem_addr_q;
        pmem_d_d    = pmem_d_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    kij_d   = '0;
                    idx_d   = '0;
                    sat_d   = 1'b0;
                    base_d  = base_addr;
                    relu_d  = relu_en;
                end
            end
            WAIT: begin
                if (ofifo_valid) begin
                    data_d      = ofifo_out;
                    pmem_addr_d = cur_addr;
                    // Pass 0 overwrites PMEM, so there is nothing to read back.
                    if (kij_q == '0) begin
                        state_d  = WR;
                        pmem_d_d = relu_apply ? relu_word(ofifo_out) : ofifo_out;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = ACC;
            ACC: begin
                state_d  = WR;
                pmem_d_d = relu_apply ? relu_word(acc_word) : acc_word;
                sat_d    = sat_q | acc_sat;
            end
            WR: begin
                if (idx_q != idx_last) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = WAIT;
                end else if (kij_q != kij_last) begin
                    idx_d   = '0;
                    kij_d   = kij_q + 1'b1;
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they align with it.
        cen_d  = !((state_d == RD) || (state_d == WR));
        wen_d  = (state_d != WR);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            kij_q       <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            relu_q      <= 1'b0;
            data_q      <= '0;
            sat_q       <= 1'b0;
            pmem_addr_q <= '0;
            pmem_d_q    <= '0;
            cen_q       <= 1'b1;
            wen_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kij_q       <= kij_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            relu_q      <= relu_d;
            data_q      <= data_d;
            sat_q       <= sat_d;
            pmem_addr_q <= pmem_addr_d;
            pmem_d_q    <= pmem_d_d;
            cen_q       <= cen_d;
            wen_q       <= wen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ofifo_rd  = (state_q == WAIT) && ofifo_valid;
    assign pmem_d    = pmem_d_q;
    assign pmem_addr = pmem_addr_q;
    assign pmem_cen  = cen_q;
    assign pmem_wen  = wen_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_psum_acc_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for psum_acc_ctrl: expected PMEM writes are queued when a
// sequence is issued and compared by monitors as the DUTs write.
module tb_psum_acc_ctrl;

    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int W     = COL * BW;
    localparam int N_OUT = 36;
    localparam int N_KIJ = 9;
    localparam int AW    = 9;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          relu_en = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [W-1:0]  ofifo_out;
    logic          ofifo_rd;
    logic [W-1:0]  pmem_q = '0;
    logic [W-1:0]  pmem_d;
    logic [AW-1:0] pmem_addr;
    logic          pmem_cen, pmem_wen, busy, done, sat_flag;

    logic          start1 = 1'b0;
    logic [AW-1:0] base1 = '0;
    logic          ofifo_valid1 = 1'b0;
    logic [W-1:0]  ofifo_out1;
    logic          ofifo_rd1;
    logic [W-1:0]  pmem_q1;
    logic [W-1:0]  pmem_d1;
    logic [AW-1:0] pmem_addr1;
    logic          pmem_cen1, pmem_wen1, busy1, done1, sat1;

    psum_acc_ctrl #(.col(COL), .psum_bw(BW), .n_out(N_OUT), .n_kij(N_KIJ), .addr_w(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .relu_en(relu_en),
        .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
        .pmem_q(pmem_q), .pmem_d(pmem_d), .pmem_addr(pmem_addr), .pmem_cen(pmem_cen),
        .pmem_wen(pmem_wen), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    psum_acc_ctrl #(.col(COL), .psum_bw(BW), .n_out(1), .n_kij(1), .addr_w(AW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .base_addr(base1), .relu_en(1'b0),
        .ofifo_valid(ofifo_valid1), .ofifo_out(ofifo_out1), .ofifo_rd(ofifo_rd1),
        .pmem_q(pmem_q1), .pmem_d(pmem_d1), .pmem_addr(pmem_addr1), .pmem_cen(pmem_cen1),
        .pmem_wen(pmem_wen1), .busy(busy1), .done(done1), .sat_flag(sat1)
    );

    assign ofifo_out1 = {COL{16'h0003}};
    assign pmem_q1    = {COL{16'hDEAD}};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // PMEM model: one-cycle read latency
    logic [W-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!pmem_cen) begin
            if (!pmem_wen) mem[pmem_addr] <= pmem_d;
            else           pmem_q <= mem[pmem_addr];
        end
    end

    // OFIFO model: the head word depends on how many words this sequence has popped
    logic [W-1:0] pass_word [N_KIJ];
    int pops_seen = 0, pops_base = 0, dones_seen = 0;
    int pass_raw;
    assign pass_raw  = (pops_seen - pops_base) / N_OUT;
    assign ofifo_out = pass_word[(pass_raw > N_KIJ - 1) ? N_KIJ - 1 : pass_raw];

    int pops1 = 0, reads1 = 0;
    wr_t exp_q[$];
    wr_t exp1_q[$];

    always @(posedge clk) begin
        if (ofifo_rd)  pops_seen <= pops_seen + 1;
        if (ofifo_rd1) pops1 <= pops1 + 1;
    end

    // Write monitors: every PMEM write must match the head of its expected queue
    always @(negedge clk) begin
        wr_t e;
        if (done) dones_seen <= dones_seen + 1;
        if (!pmem_cen && !pmem_wen) begin
            if (exp_q.size() == 0) begin
                fail_event("unexpected_write", $sformatf("write addr %0h, expected none", pmem_addr));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", W'(pmem_addr), W'(e.addr));
                check("wr_data", pmem_d, e.data);
            end
        end
        if (!pmem_cen1 && pmem_wen1) reads1 <= reads1 + 1;
        if (!pmem_cen1 && !pmem_wen1) begin
            if (exp1_q.size() == 0) begin
                fail_event("single_unexpected_write", $sformatf("write addr %0h, expected none", pmem_addr1));
            end else begin
                e = exp1_q.pop_front();
                check("single_wr_addr", W'(pmem_addr1), W'(e.addr));
                check("single_wr_data", pmem_d1, e.data);
            end
        end
    end

    // Reference model of one full sequence; pushes every expected write
    task automatic build_exp(input logic [AW-1:0] base, input logic relu,
                             output logic sat_e, output logic [W-1:0] fin);
        int a [COL];
        logic [W-1:0] word;
        sat_e = 1'b0;
        fin   = '0;
        word  = '0;
        for (int k = 0; k < N_KIJ; k++) begin
            for (int l = 0; l < COL; l++) begin
                int w;
                w = $signed(pass_word[k][l*BW +: BW]);
                a[l] = (k == 0) ? w : a[l] + w;
                if (a[l] > 32767)  begin a[l] = 32767;  sat_e = 1'b1; end
                if (a[l] < -32768) begin a[l] = -32768; sat_e = 1'b1; end
                word[l*BW +: BW] = (relu && k == N_KIJ - 1 && a[l] < 0) ? 16'h0000 : BW'(a[l]);
            end
            for (int i = 0; i < N_OUT; i++) exp_q.push_back('{addr: base + AW'(i), data: word});
            fin = word;
        end
    endtask

    task automatic issue_start(input logic [AW-1:0] base, input logic relu);
        pops_base = pops_seen;
        @(negedge clk);
        base_addr   = base;
        relu_en     = relu;
        start       = 1'b1;
        ofifo_valid = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = ~base;
        relu_en   = ~relu;
    endtask

    task automatic run_seq(input string name, input logic [AW-1:0] base, input logic relu, input bit stall);
        logic sat_e;
        logic [W-1:0] fin;
        int busy_cyc, cyc, done_base;
        bit got_done, stalled, stall_bad;
        done_base = dones_seen;
        build_exp(base, relu, sat_e, fin);
        issue_start(base, relu);
        check({name, "_sat_clear"}, W'(sat_flag), W'(0));
        check({name, "_busy"}, W'(busy), W'(1));
        busy_cyc = 1;
        cyc = 0;
        got_done = 0;
        stalled = 0;
        stall_bad = 0;
        while (!got_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) got_done = 1;
            if (stall && !stalled && (pops_seen - pops_base) >= 100) begin
                stalled = 1;
                ofifo_valid = 1'b0;
                repeat (4) @(negedge clk);
                for (int s = 0; s < 10; s++) begin
                    if (s == 4) begin start = 1'b1; base_addr = 9'd7; relu_en = ~relu; end
                    if (s == 5) start = 1'b0;
                    @(negedge clk);
                    if (!pmem_cen || ofifo_rd || !busy || done) stall_bad = 1;
                end
                check({name, "_stall_hold"}, W'(stall_bad), W'(0));
                ofifo_valid = 1'b1;
            end
        end
        if (!got_done) fail_event({name, "_done"}, "timeout, expected done pulse");
        if (!stall) check({name, "_cycles"}, W'(busy_cyc), W'(N_OUT * 2 + (N_KIJ - 1) * N_OUT * 4 + 1));
        repeat (2) @(negedge clk);
        check({name, "_done_count"}, W'(dones_seen - done_base), W'(1));
        check({name, "_pops"}, W'(pops_seen - pops_base), W'(N_OUT * N_KIJ));
        check({name, "_sat_flag"}, W'(sat_flag), W'(sat_e));
        check({name, "_idle"}, W'(busy), W'(0));
        check({name, "_drained"}, W'(exp_q.size()), W'(0));
        for (int i = 0; i < N_OUT; i++) check({name, "_final"}, mem[base + AW'(i)], fin);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        logic sat_e;
        logic [W-1:0] fin;

        for (int k = 0; k < N_KIJ; k++) pass_word[k] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_rd", W'(ofifo_rd), W'(0));
        check("rst_cen", W'(pmem_cen), W'(1));
        check("rst_wen", W'(pmem_wen), W'(1));
        check("rst_addr", W'(pmem_addr), W'(0));
        check("rst_d", pmem_d, W'(0));
        check("rst_sat", W'(sat_flag), W'(0));

        // Single-word instance: start on the very first edge out of reset
        exp1_q.push_back('{addr: 9'd5, data: {COL{16'h0003}}});
        reset = 1'b1; start1 = 1'b1; base1 = 9'd5; ofifo_valid1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; base1 = 9'd0;
        check("single_busy", W'(busy1), W'(1));
        check("single_pop", W'(ofifo_rd1), W'(1));
        n = 0;
        while (!done1 && n < 20) begin @(negedge clk); n++; end
        check("single_done_latency", W'(n), W'(2));
        ofifo_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        check("single_pops", W'(pops1), W'(1));
        check("single_no_read", W'(reads1), W'(0));
        check("single_drained", W'(exp1_q.size()), W'(0));

        // Accumulation with address wrap: lanes of pass k are k+1, final 45
        for (int k = 0; k < N_KIJ; k++) pass_word[k] = {COL{16'(k + 1)}};
        run_seq("accum", 9'd490, 1'b0, 0);

        // Positive saturation in lane 0
        for (int k = 0; k < N_KIJ; k++) pass_word[k] = '0;
        pass_word[0] = {COL{16'h0001}};
        pass_word[0][BW-1:0] = 16'h7FF0;
        pass_word[1][BW-1:0] = 16'h0020;
        run_seq("sat_pos", 9'd0, 1'b0, 0);

        // Negative saturation in lane 1
        for (int k = 0; k < N_KIJ; k++) pass_word[k] = '0;
        pass_word[0][2*BW-1:BW] = 16'h8010;
        pass_word[1][2*BW-1:BW] = 16'hFFE0;
        run_seq("sat_neg", 9'd100, 1'b0, 0);

        // ReLU on the final pass, with a stall and an ignored start mid-run
        for (int k = 0; k < N_KIJ; k++) pass_word[k] = '0;
        pass_word[0][BW-1:0]      = 16'hFFF9;
        pass_word[0][2*BW-1:BW]   = 16'h0005;
        pass_word[0][3*BW-1:2*BW] = 16'hFFFC;
        pass_word[0][4*BW-1:3*BW] = 16'hFFF6;
        pass_word[8][3*BW-1:2*BW] = 16'h0004;
        pass_word[8][4*BW-1:3*BW] = 16'h0003;
        run_seq("relu_on", 9'd150, 1'b1, 1);
        run_seq("relu_off", 9'd200, 1'b0, 0);

        // Reset during a pass-3 read, then a clean rerun
        for (int k = 0; k < N_KIJ; k++) pass_word[k] = {COL{16'(k + 1)}};
        build_exp(9'd250, 1'b0, sat_e, fin);
        issue_start(9'd250, 1'b0);
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if ((pops_seen - pops_base) >= 3 * N_OUT + 2 && !pmem_cen && pmem_wen) found = 1;
        end
        if (!found) fail_event("abort_rd", "timeout, expected pass-3 read");
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_cen", W'(pmem_cen), W'(1));
        check("abort_wen", W'(pmem_wen), W'(1));
        check("abort_busy", W'(busy), W'(0));
        check("abort_addr", W'(pmem_addr), W'(0));
        check("abort_rd_strobe", W'(ofifo_rd), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_seq("rerun", 9'd300, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
